svc_rst_seq: RTL and testbench

// Parametrised multi-channel reset sequencer. Takes one asynchronous system reset
// and synchronises its release. It holds all downstream resets for a fixed

---
 rtl/svc_rst_seq.sv | 134 +++++++++++++
 tb/tb_svc_rst_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/svc_rst_seq.sv
// svc_rst_seq - multi-channel reset sequencer.
//
// Synchronises the release of an asynchronous system reset, holds every
// downstream reset domain for HOLD_CYCLES, then releases the NUM_CH domains one
// at a time in ascending index order, STAGGER_CYCLES apart. Once running, it
// serves software reset requests on a subset of channels with the same
// hold/stagger timing.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   sw_rst_req  software reset request, sampled on the clk rising edge
//   ch_mask     channels reset by sw_rst_req, sampled with it
//   rst_out     per-channel active-high reset (registered)
//   busy        a sequence is in progress; new requests are ignored
//   done        one-cycle pulse when a sequence completes
module svc_rst_seq #(
  parameter int NUM_CH         = 4,
  parameter int HOLD_CYCLES    = 10,
  parameter int STAGGER_CYCLES = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_rst_req,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [NUM_CH-1:0] rst_out,
  output logic              busy,
  output logic              done
);

  localparam int MAX_CNT = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_CH-1:0]      pend_q, pend_d;
  logic [NUM_CH-1:0]      rst_out_d;
  logic                   busy_d, done_d;
  logic [NUM_CH-1:0]      low_bit;
  logic                   last_ch;
  logic                   rel;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Lowest pending channel is the next to release; when it is the only one
  // left, this release ends the sequence.
  assign low_bit = pend_q & (~pend_q + NUM_CH'(1));
  assign last_ch = ((pend_q & ~low_bit) == '0);

  always_comb begin
    state_d   = state_q;
    sync_d    = sync_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    rst_out_d = rst_out;
    busy_d    = busy;
    done_d    = 1'b0;
    rel       = 1'b0;

    case (state_q)
      SYNC: begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};
        // Leave on the edge that shifts the last 1 out of the chain.
        if (sync_q[SYNC_STAGES-2:0] == '0) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) rel = 1'b1;
        else                                 cnt_d = sat_inc(cnt_q);
      end
      RELEASE: begin
        if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) rel = 1'b1;
        else                                    cnt_d = sat_inc(cnt_q);
      end
      RUN: begin
        if (sw_rst_req && (ch_mask != '0)) begin
          state_d   = HOLD;
          pend_d    = ch_mask;
          rst_out_d = rst_out | ch_mask;
          busy_d    = 1'b1;
          cnt_d     = '0;
        end
      end
      default: state_d = SYNC;
    endcase

    if (rel) begin
      rst_out_d = rst_out & ~low_bit;
      pend_d    = pend_q & ~low_bit;
      cnt_d     = '0;
      if (last_ch) begin
        state_d = RUN;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = RELEASE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SYNC;
      sync_q  <= '1;
      cnt_q   <= '0;
      pend_q  <= '1;
      rst_out <= '1;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      rst_out <= rst_out_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_svc_rst_seq.sv
// Testbench for svc_rst_seq: randomized requests against a timeline model,
// with a queue-based scoreboard, plus a small single-channel instance.
module tb_svc_rst_seq;

  localparam int N  = 4;
  localparam int H  = 10;
  localparam int ST = 4;
  localparam int S  = 2;

  logic         clk = 1'b0;
  logic         rst, sw_rst_req;
  logic [N-1:0] ch_mask, rst_out;
  logic         busy, done;

  logic         rst2, sw2;
  logic [0:0]   mask2, rst_out2;
  logic         busy2, done2;

  always #5 clk = ~clk;

  svc_rst_seq #(.NUM_CH(N), .HOLD_CYCLES(H), .STAGGER_CYCLES(ST), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .ch_mask(ch_mask),
    .rst_out(rst_out), .busy(busy), .done(done));

  svc_rst_seq #(.NUM_CH(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst(rst2), .sw_rst_req(sw2), .ch_mask(mask2),
    .rst_out(rst_out2), .busy(busy2), .done(done2));

  typedef struct packed {
    logic [N-1:0] r;
    logic         b;
    logic         d;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Timeline model: each channel has an absolute fall edge, counted from
  // reset release (edge 1 = first rising edge with rst low).
  int           n;
  int           fall[N];
  int           last_fall;
  logic         mbusy;
  logic [N-1:0] mrst;

  task automatic model_step();
    exp_t e;
    int   j;
    if (rst) begin
      n     = 0;
      mbusy = 1'b1;
      mrst  = '1;
      for (int i = 0; i < N; i++) fall[i] = S + H + ST * i;
      last_fall = S + H + ST * (N - 1);
      e.d = 1'b0;
      q.delete();
    end else begin
      n++;
      e.d = 1'b0;
      if (mbusy) begin
        for (int i = 0; i < N; i++) if (fall[i] == n) mrst[i] = 1'b0;
        if (n == last_fall) begin
          mbusy = 1'b0;
          e.d   = 1'b1;
        end
      end else if (sw_rst_req && (ch_mask != '0)) begin
        j = 0;
        for (int i = 0; i < N; i++) begin
          if (ch_mask[i]) begin
            fall[i]   = n + H + ST * j;
            last_fall = fall[i];
            mrst[i]   = 1'b1;
            j++;
          end else begin
            fall[i] = -1;
          end
        end
        mbusy = 1'b1;
      end
    end
    e.r = mrst;
    e.b = mbusy;
    q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  // Monitor: compares the DUT against the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rst_out", 32'(rst_out), 32'(e.r));
        chk("busy", 32'(busy), 32'(e.b));
        chk("done", 32'(done), 32'(e.d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sw_rst_req = 1'b0; ch_mask = '0;
    rst2 = 1'b1; sw2 = 1'b0; mask2 = '0;
    repeat (5) @(negedge clk);

    // Power-on with a request held high throughout the sequence.
    sw_rst_req = 1'b1; ch_mask = 4'hF; rst = 1'b0;
    repeat (24) @(negedge clk);
    sw_rst_req = 1'b0; ch_mask = '0;
    repeat (4) @(negedge clk);

    // Sparse mask.
    sw_rst_req = 1'b1; ch_mask = 4'b0101;
    @(negedge clk);
    sw_rst_req = 1'b0; ch_mask = '0;
    repeat (20) @(negedge clk);

    // Empty mask is ignored.
    sw_rst_req = 1'b1; ch_mask = '0;
    @(negedge clk);
    sw_rst_req = 1'b0;
    repeat (3) @(negedge clk);

    // Random traffic.
    repeat (800) begin
      @(negedge clk);
      sw_rst_req = ($urandom_range(0, 7) == 0);
      ch_mask    = N'($urandom);
    end
    sw_rst_req = 1'b0; ch_mask = '0;
    repeat (40) @(negedge clk);

    // Fresh power-on, then async reset mid-cycle after edge 18.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (17) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    // Single-channel instance with minimal timing.
    chk("dut2 reset rst_out", 32'(rst_out2), 32'd1);
    chk("dut2 reset busy", 32'(busy2), 32'd1);
    chk("dut2 reset done", 32'(done2), 32'd0);
    rst2 = 1'b0;
    @(negedge clk);
    chk("dut2 edge1 rst_out", 32'(rst_out2), 32'd1);
    @(negedge clk);
    chk("dut2 edge2 rst_out", 32'(rst_out2), 32'd1);
    chk("dut2 edge2 done", 32'(done2), 32'd0);
    @(negedge clk);
    chk("dut2 edge3 rst_out", 32'(rst_out2), 32'd0);
    chk("dut2 edge3 done", 32'(done2), 32'd1);
    chk("dut2 edge3 busy", 32'(busy2), 32'd0);
    @(negedge clk);
    chk("dut2 edge4 done", 32'(done2), 32'd0);
    sw2 = 1'b1; mask2 = 1'b1;
    @(negedge clk);
    sw2 = 1'b0; mask2 = 1'b0;
    chk("dut2 R rst_out", 32'(rst_out2), 32'd1);
    chk("dut2 R busy", 32'(busy2), 32'd1);
    chk("dut2 R done", 32'(done2), 32'd0);
    @(negedge clk);
    chk("dut2 R+1 rst_out", 32'(rst_out2), 32'd0);
    chk("dut2 R+1 done", 32'(done2), 32'd1);
    chk("dut2 R+1 busy", 32'(busy2), 32'd0);
    @(negedge clk);
    chk("dut2 R+2 done", 32'(done2), 32'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
